// File: rtl/blob_pkg.sv
// Shared types and helpers for the blob bounding-box consumer.
package blob_pkg;

  localparam int unsigned X_W = 9;
  localparam int unsigned Y_W = 8;

  typedef logic [X_W-1:0] coord_x_t;
  typedef logic [Y_W-1:0] coord_y_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    FILTER = 2'd2,
    OUTPUT = 2'd3
  } state_e;

  // Floor midpoint with one extra bit so the sum never wraps.
  function automatic coord_x_t mid_x(input coord_x_t lo, input coord_x_t hi);
    logic [X_W:0] s;
    s = {1'b0, lo} + {1'b0, hi};
    return X_W'(s >> 1);
  endfunction

  function automatic coord_y_t mid_y(input coord_y_t lo, input coord_y_t hi);
    logic [Y_W:0] s;
    s = {1'b0, lo} + {1'b0, hi};
    return Y_W'(s >> 1);
  endfunction

endpackage

// File: rtl/blob_avg_filter.sv
// Moving-average smoother for one axis: history shift register with prime/shift
// control; avg_c reflects the history as it will be after the current cycle.
module blob_avg_filter #(
  parameter int unsigned WIDTH    = 9,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             restart,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] avg_c
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned SUM_W = WIDTH + AVG_LOG2;

  logic [WIDTH-1:0] hist_q [DEPTH];
  logic [WIDTH-1:0] hist_d [DEPTH];
  logic             primed_q;
  logic             primed_d;
  logic [SUM_W-1:0] sum_c;

  always_comb begin
    hist_d   = hist_q;
    primed_d = primed_q;
    if (load) begin
      // A stale or empty history is flooded so the first output equals the sample.
      if (!primed_q || restart) begin
        for (int i = 0; i < int'(DEPTH); i++) hist_d[i] = din;
        primed_d = 1'b1;
      end else begin
        for (int i = int'(DEPTH) - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
        hist_d[0] = din;
      end
    end
    sum_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) sum_c = sum_c + SUM_W'(hist_d[i]);
    avg_c = WIDTH'(sum_c >> AVG_LOG2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) hist_q[i] <= '0;
      primed_q <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      primed_q <= primed_d;
    end
  end

endmodule

// File: rtl/blob_center_tracker.sv
// Validates incoming bounding boxes, smooths their centre and flags target loss
// when no box has been accepted for TIMEOUT cycles.
module blob_center_tracker
  import blob_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 2,
  parameter logic [31:0] TIMEOUT  = 32'h004F0000
) (
  input  logic           iClock,
  input  logic           iReset,
  input  logic           iNewCoord,
  input  logic [X_W-1:0] iXmin,
  input  logic [X_W-1:0] iXmax,
  input  logic [Y_W-1:0] iYmin,
  input  logic [Y_W-1:0] iYmax,
  output logic           oCenterValid,
  output logic [X_W-1:0] oCenterX,
  output logic [Y_W-1:0] oCenterY,
  output logic [X_W-1:0] oWidth,
  output logic [Y_W-1:0] oHeight,
  output logic           oInvalid,
  output logic           oDrop,
  output logic           oBusy,
  output logic           oLost
);

  state_e   state_q, state_d;
  coord_x_t xmin_q, xmin_d, xmax_q, xmax_d;
  coord_y_t ymin_q, ymin_d, ymax_q, ymax_d;
  coord_x_t cx_q, cx_d, w_q, w_d;
  coord_y_t cy_q, cy_d, h_q, h_d;
  coord_x_t center_x_q, center_x_d, width_q, width_d;
  coord_y_t center_y_q, center_y_d, height_q, height_d;
  logic     valid_q, valid_d;
  logic     invalid_q, invalid_d;
  logic     drop_q, drop_d;
  logic     busy_q, busy_d;
  logic     lost_q, lost_d;
  logic [31:0] cnt_q, cnt_d;

  logic     filt_load;
  coord_x_t avg_x_c;
  coord_y_t avg_y_c;

  blob_avg_filter #(.WIDTH(X_W), .AVG_LOG2(AVG_LOG2)) u_avg_x (
    .clk     (iClock),
    .rst_n   (iReset),
    .load    (filt_load),
    .restart (lost_q),
    .din     (cx_q),
    .avg_c   (avg_x_c)
  );

  blob_avg_filter #(.WIDTH(Y_W), .AVG_LOG2(AVG_LOG2)) u_avg_y (
    .clk     (iClock),
    .rst_n   (iReset),
    .load    (filt_load),
    .restart (lost_q),
    .din     (cy_q),
    .avg_c   (avg_y_c)
  );

  always_comb begin
    state_d    = state_q;
    xmin_d     = xmin_q;
    xmax_d     = xmax_q;
    ymin_d     = ymin_q;
    ymax_d     = ymax_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    w_d        = w_q;
    h_d        = h_q;
    center_x_d = center_x_q;
    center_y_d = center_y_q;
    width_d    = width_q;
    height_d   = height_q;
    valid_d    = 1'b0;
    invalid_d  = 1'b0;
    drop_d     = iNewCoord && (state_q != IDLE);
    filt_load  = 1'b0;
    cnt_d      = cnt_q;
    lost_d     = lost_q;

    unique case (state_q)
      IDLE: begin
        if (iNewCoord) begin
          xmin_d  = iXmin;
          xmax_d  = iXmax;
          ymin_d  = iYmin;
          ymax_d  = iYmax;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if ((xmin_q > xmax_q) || (ymin_q > ymax_q)) begin
          invalid_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cx_d    = mid_x(xmin_q, xmax_q);
          cy_d    = mid_y(ymin_q, ymax_q);
          w_d     = xmax_q - xmin_q;
          h_d     = ymax_q - ymin_q;
          state_d = FILTER;
        end
      end
      FILTER: begin
        // Results land together with the pulse so they are valid during OUTPUT.
        filt_load  = 1'b1;
        center_x_d = avg_x_c;
        center_y_d = avg_y_c;
        width_d    = w_q;
        height_d   = h_q;
        valid_d    = 1'b1;
        state_d    = OUTPUT;
      end
      OUTPUT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // An accepted box clears the watchdog even on the cycle it would have expired.
    if (state_q == FILTER) begin
      cnt_d  = '0;
      lost_d = 1'b0;
    end else if (cnt_q != TIMEOUT) begin
      cnt_d = cnt_q + 32'd1;
      if (cnt_d == TIMEOUT) lost_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q    <= IDLE;
      xmin_q     <= '0;
      xmax_q     <= '0;
      ymin_q     <= '0;
      ymax_q     <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      center_x_q <= '0;
      center_y_q <= '0;
      width_q    <= '0;
      height_q   <= '0;
      valid_q    <= 1'b0;
      invalid_q  <= 1'b0;
      drop_q     <= 1'b0;
      busy_q     <= 1'b0;
      lost_q     <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      xmin_q     <= xmin_d;
      xmax_q     <= xmax_d;
      ymin_q     <= ymin_d;
      ymax_q     <= ymax_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      w_q        <= w_d;
      h_q        <= h_d;
      center_x_q <= center_x_d;
      center_y_q <= center_y_d;
      width_q    <= width_d;
      height_q   <= height_d;
      valid_q    <= valid_d;
      invalid_q  <= invalid_d;
      drop_q     <= drop_d;
      busy_q     <= busy_d;
      lost_q     <= lost_d;
      cnt_q      <= cnt_d;
    end
  end

  assign oCenterValid = valid_q;
  assign oCenterX     = center_x_q;
  assign oCenterY     = center_y_q;
  assign oWidth       = width_q;
  assign oHeight      = height_q;
  assign oInvalid     = invalid_q;
  assign oDrop        = drop_q;
  assign oBusy        = busy_q;
  assign oLost        = lost_q;

endmodule

// File: tb/tb_blob_center_tracker.sv
// Scoreboard bench: stimulus queues expected events, a forked monitor checks them.
module tb_blob_center_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       new_coord;
  logic [8:0] xmin, xmax;
  logic [7:0] ymin, ymax;
  logic       center_valid, invalid, drop, busy, lost;
  logic [8:0] center_x, width;
  logic [7:0] center_y, height;

  always #5 clk = ~clk;

  blob_center_tracker #(.AVG_LOG2(2), .TIMEOUT(32'd100)) dut (
    .iClock       (clk),
    .iReset       (rst_n),
    .iNewCoord    (new_coord),
    .iXmin        (xmin),
    .iXmax        (xmax),
    .iYmin        (ymin),
    .iYmax        (ymax),
    .oCenterValid (center_valid),
    .oCenterX     (center_x),
    .oCenterY     (center_y),
    .oWidth       (width),
    .oHeight      (height),
    .oInvalid     (invalid),
    .oDrop        (drop),
    .oBusy        (busy),
    .oLost        (lost)
  );

  typedef struct {
    logic [8:0] x;
    logic [7:0] y;
    logic [8:0] w;
    logic [7:0] h;
  } exp_t;

  exp_t center_q[$];
  int   invalid_pend = 0;
  int   drop_pend    = 0;
  int   n_cmp        = 0;
  int   n_err        = 0;
  exp_t last_out;

  logic [8:0] seq_xmin [4] = '{9'h008, 9'h018, 9'h028, 9'h038};
  logic [8:0] seq_xmax [4] = '{9'h018, 9'h028, 9'h038, 9'h048};
  logic [8:0] seq_cx   [4] = '{9'h010, 9'h014, 9'h01C, 9'h028};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event occurred with nothing expected at %0t", name, $time);
  endtask

  task automatic push_center(input logic [8:0] x, input logic [7:0] y,
                             input logic [8:0] w, input logic [7:0] h);
    exp_t e;
    e.x = x; e.y = y; e.w = w; e.h = h;
    center_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_out.x = '0; last_out.y = '0; last_out.w = '0; last_out.h = '0;
      end
      if (center_valid) begin
        if (center_q.size() == 0) flag("center_valid");
        else begin
          e = center_q.pop_front();
          chk("center_x", 32'(center_x), 32'(e.x));
          chk("center_y", 32'(center_y), 32'(e.y));
          chk("width",    32'(width),    32'(e.w));
          chk("height",   32'(height),   32'(e.h));
          last_out = e;
        end
      end
      if (invalid) begin
        if (invalid_pend == 0) flag("invalid");
        else begin
          invalid_pend--;
          chk("hold_x", 32'(center_x), 32'(last_out.x));
          chk("hold_y", 32'(center_y), 32'(last_out.y));
          chk("hold_w", 32'(width),    32'(last_out.w));
          chk("hold_h", 32'(height),   32'(last_out.h));
        end
      end
      if (drop) begin
        if (drop_pend == 0) flag("drop");
        else drop_pend--;
      end
    end
  endtask

  task automatic send_box(input logic [8:0] x0, input logic [8:0] x1,
                          input logic [7:0] y0, input logic [7:0] y1);
    @(negedge clk);
    xmin = x0; xmax = x1; ymin = y0; ymax = y1;
    new_coord = 1'b1;
    @(negedge clk);
    new_coord = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n++;
      if (center_valid) return;
    end
    flag("valid_timeout");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    new_coord = 1'b0;
    xmin = '0; xmax = '0; ymin = '0; ymax = '0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk("rst_lost",  32'(lost), 32'd1);
    chk("rst_valid", 32'(center_valid), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_cx",    32'(center_x), 32'd0);
    rst_n = 1'b1;

    // Basic box; capture edge then valid on the 2nd following negedge.
    push_center(9'h020, 8'h30, 9'h020, 8'h20);
    send_box(9'h010, 9'h030, 8'h20, 8'h40);
    wait_valid(n);
    chk("latency", 32'(n), 32'd2);
    chk("lost_cleared", 32'(lost), 32'd0);
    repeat (3) @(negedge clk);

    // Moving average from fresh history.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_center(seq_cx[i], 8'h10, 9'h010, 8'h00);
      send_box(seq_xmin[i], seq_xmax[i], 8'h10, 8'h10);
      wait_valid(n);
      if (i < 3) repeat (2) @(negedge clk);
    end

    // Loss exactly TIMEOUT edges after the clearing edge.
    repeat (99) @(negedge clk);
    chk("lost_at_99", 32'(lost), 32'd0);
    @(negedge clk);
    chk("lost_at_100", 32'(lost), 32'd1);

    // Rejected box: outputs held, loss unaffected.
    invalid_pend++;
    send_box(9'h050, 9'h040, 8'h00, 8'h10);
    repeat (4) @(negedge clk);
    chk("lost_after_invalid", 32'(lost), 32'd1);

    // Degenerate box is valid and re-primes after loss.
    push_center(9'h090, 8'h22, 9'h000, 8'h00);
    send_box(9'h090, 9'h090, 8'h22, 8'h22);
    wait_valid(n);
    repeat (105) @(negedge clk);
    chk("lost_again", 32'(lost), 32'd1);

    push_center(9'h080, 8'h40, 9'h020, 8'h20);
    send_box(9'h070, 9'h090, 8'h30, 8'h50);
    wait_valid(n);
    repeat (2) @(negedge clk);

    // Back-to-back request: second is dropped; Y blends 0x07 into 0x40 history.
    push_center(9'h080, 8'h31, 9'h03F, 8'h05);
    drop_pend++;
    @(negedge clk);
    xmin = 9'h061; xmax = 9'h0A0; ymin = 8'h05; ymax = 8'h0A;
    new_coord = 1'b1;
    @(negedge clk);
    xmin = 9'h000; xmax = 9'h010; ymin = 8'h00; ymax = 8'h10;
    @(negedge clk);
    new_coord = 1'b0;
    wait_valid(n);
    repeat (3) @(negedge clk);

    // Asynchronous reset while in CHECK.
    send_box(9'h000, 9'h1FF, 8'h00, 8'hFF);
    chk("busy_in_check", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_cx",   32'(center_x), 32'd0);
    chk("async_w",    32'(width), 32'd0);
    chk("async_lost", 32'(lost), 32'd1);
    chk("async_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Full-range box after reset primes fresh history.
    push_center(9'h0FF, 8'h7F, 9'h1FF, 8'hFF);
    send_box(9'h000, 9'h1FF, 8'h00, 8'hFF);
    wait_valid(n);
    repeat (3) @(negedge clk);

    chk("centers_left",  32'(center_q.size()), 32'd0);
    chk("invalid_left",  32'(invalid_pend), 32'd0);
    chk("drop_left",     32'(drop_pend), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
